// File: rtl/port_uart_tx.sv
// port_uart_tx: word FIFO feeding an 8N1 UART serializer, four bytes per word, LSB byte first.
module port_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          WrEn,
  input  logic [31:0]                   WrData,
  output logic                          Full,
  output logic                          Empty,
  output logic [$clog2(FIFO_DEPTH):0]   Count,
  output logic                          TxBusy,
  output logic                          Tx,
  output logic                          Overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] ONE   = (AW+1)'(1);
  localparam logic [15:0] LAST  = 16'(CLKS_PER_BIT - 1);

  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          full_q, empty_q, overflow_q;
  logic [1:0]    state_q, state_d;
  logic [15:0]   timer_q, timer_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic [31:0]   shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          pop, push, bit_end;

  assign pop     = (state_q == IDLE) && !empty_q;
  assign push    = WrEn && (!full_q || pop);
  assign bit_end = timer_q == LAST;
  assign count_d = (push && !pop) ? count_q + ONE : (pop && !push) ? count_q - ONE : count_q;

  always_comb begin
    state_d = state_q;
    timer_d = (state_q == IDLE || bit_end) ? 16'd0 : timer_q + 16'd1;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    if (state_q == IDLE) begin
      if (pop) begin
        state_d = START;
        shift_d = mem_q[rd_ptr_q];
        byte_d  = 2'd0;
        tx_d    = 1'b0;
      end
    end else if (bit_end) begin
      case (state_q)
        START: begin
          state_d = DATA;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end
        DATA: begin
          state_d = (bit_q == 3'd7) ? STOP : DATA;
          bit_d   = bit_q + 3'd1;
          tx_d    = (bit_q == 3'd7) ? 1'b1 : shift_q[bit_q + 3'd1];
        end
        default: begin
          state_d = (byte_q == 2'd3) ? IDLE : START;
          byte_d  = (byte_q == 2'd3) ? byte_q : byte_q + 2'd1;
          shift_d = (byte_q == 2'd3) ? shift_q : shift_q >> 8;
          tx_d    = byte_q == 2'd3;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      state_q    <= IDLE;
      timer_q    <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      wr_ptr_q   <= push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_q   <= pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_q    <= count_d;
      full_q     <= count_d == DEPTH;
      empty_q    <= count_d == '0;
      overflow_q <= overflow_q | (WrEn && !push);
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[wr_ptr_q] <= WrData;
  end

  assign Full     = full_q;
  assign Empty    = empty_q;
  assign Count    = count_q;
  assign TxBusy   = state_q != IDLE;
  assign Tx       = tx_q;
  assign Overflow = overflow_q;
endmodule

// File: tb/tb_port_uart_tx.sv
// tb_port_uart_tx: directed checks of FIFO behaviour and UART framing via an independent receiver.
module tb_port_uart_tx;
  localparam int C = 4;
  localparam int D = 4;

  logic        clk = 1'b0, reset = 1'b1, WrEn = 1'b0;
  logic [31:0] WrData = '0;
  logic        Full, Empty, TxBusy, Tx, Overflow;
  logic [2:0]  Count;
  int          tests = 0, fails = 0, cyc = 0, stop_err = 0;
  logic [7:0]  rx_q[$];
  int          rx_t[$];
  logic [31:0] exp_w[$];

  port_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .WrEn(WrEn), .WrData(WrData), .Full(Full), .Empty(Empty),
    .Count(Count), .TxBusy(TxBusy), .Tx(Tx), .Overflow(Overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Receiver: detect a start bit, then sample each following bit once per bit period.
  initial begin : rx
    logic [7:0] b;
    int t0;
    bit bad;
    forever begin
      @(negedge clk);
      if (!reset && Tx === 1'b0) begin
        t0 = cyc;
        b = '0;
        bad = 1'b0;
        for (int i = 0; i < 9; i++) begin
          repeat (C) begin
            @(negedge clk);
            if (reset) bad = 1'b1;
          end
          if (i < 8) b[i] = Tx;
          else if (Tx !== 1'b1 && !bad) stop_err++;
        end
        if (!bad) begin
          rx_q.push_back(b);
          rx_t.push_back(t0);
        end
      end
    end
  end

  task automatic write_word(input logic [31:0] d);
    WrEn = 1'b1;
    WrData = d;
    @(negedge clk);
    WrEn = 1'b0;
  endtask

  task automatic wait_done(input int max, output bit to);
    int n = 0;
    while ((TxBusy || !Empty) && n < max) begin
      @(negedge clk);
      n++;
    end
    to = n >= max;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    WrEn = 1'b1;
    WrData = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    tests++;
    if ({Tx, TxBusy, Full, Empty, Count, Overflow} !== {1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0}) begin
      fails++;
      $display("FAIL reset_state got Tx=%b Busy=%b Full=%b Empty=%b Count=%0d Ovf=%b want 1 0 0 1 0 0",
               Tx, TxBusy, Full, Empty, Count, Overflow);
    end
    WrEn = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (Count !== 3'd0 || TxBusy !== 1'b0 || Tx !== 1'b1) begin
      fails++;
      $display("FAIL reset_wren_ignored got Count=%0d Busy=%b Tx=%b want 0 0 1", Count, TxBusy, Tx);
    end
  endtask

  task automatic test_single;
    int n;
    logic [31:0] w;
    rx_q.delete();
    rx_t.delete();
    write_word(32'h44332211);
    tests++;
    if (Count !== 3'd1 || Empty !== 1'b0 || TxBusy !== 1'b0 || Tx !== 1'b1) begin
      fails++;
      $display("FAIL single_latency_n got Count=%0d Empty=%b Busy=%b Tx=%b want 1 0 0 1", Count, Empty, TxBusy, Tx);
    end
    @(negedge clk);
    tests++;
    if (Count !== 3'd0 || Empty !== 1'b1 || TxBusy !== 1'b1 || Tx !== 1'b0) begin
      fails++;
      $display("FAIL single_latency_n1 got Count=%0d Empty=%b Busy=%b Tx=%b want 0 1 1 0", Count, Empty, TxBusy, Tx);
    end
    n = 1;
    @(negedge clk);
    while (TxBusy && n < 400) begin
      n++;
      @(negedge clk);
    end
    tests++;
    if (n !== 40 * C) begin
      fails++;
      $display("FAIL single_duration got %0d cycles want %0d", n, 40 * C);
    end
    repeat (2) @(negedge clk);
    tests++;
    if (rx_q.size() !== 4 || Tx !== 1'b1) begin
      fails++;
      $display("FAIL single_bytes got %0d bytes Tx=%b want 4 bytes Tx=1", rx_q.size(), Tx);
    end
    w = 32'h44332211;
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (k >= rx_q.size() || rx_q[k] !== w[8*k +: 8]) begin
        fails++;
        $display("FAIL single_byte%0d got %h want %h", k, (k < rx_q.size()) ? rx_q[k] : 8'hxx, w[8*k +: 8]);
      end
    end
    for (int k = 0; k + 1 < rx_t.size(); k++) begin
      tests++;
      if (rx_t[k+1] - rx_t[k] !== 10 * C) begin
        fails++;
        $display("FAIL single_gap%0d got %0d want %0d", k, rx_t[k+1] - rx_t[k], 10 * C);
      end
    end
    tests++;
    if (stop_err !== 0) begin
      fails++;
      $display("FAIL single_stop_bits got %0d bad stop bits want 0", stop_err);
    end
  endtask

  task automatic test_fill;
    bit to;
    logic [31:0] w;
    rx_q.delete();
    rx_t.delete();
    exp_w = '{32'h01020304, 32'hA5A55A5A, 32'h00FF00FF, 32'h13579BDF, 32'hFEDCBA98};
    foreach (exp_w[i]) write_word(exp_w[i]);
    tests++;
    if (Count !== 3'd4 || Full !== 1'b1 || Overflow !== 1'b0 || TxBusy !== 1'b1) begin
      fails++;
      $display("FAIL fill_full got Count=%0d Full=%b Ovf=%b Busy=%b want 4 1 0 1", Count, Full, Overflow, TxBusy);
    end
    write_word(32'hBAD0BAD0);
    tests++;
    if (Count !== 3'd4 || Full !== 1'b1 || Overflow !== 1'b1) begin
      fails++;
      $display("FAIL fill_drop got Count=%0d Full=%b Ovf=%b want 4 1 1", Count, Full, Overflow);
    end
    wait_done(2000, to);
    tests++;
    if (to || rx_q.size() !== 20 || Overflow !== 1'b1) begin
      fails++;
      $display("FAIL fill_drain got timeout=%b bytes=%0d Ovf=%b want 0 20 1", to, rx_q.size(), Overflow);
    end
    for (int k = 0; k < 20; k++) begin
      w = exp_w[k/4];
      tests++;
      if (k >= rx_q.size() || rx_q[k] !== w[8*(k%4) +: 8]) begin
        fails++;
        $display("FAIL fill_byte%0d got %h want %h", k, (k < rx_q.size()) ? rx_q[k] : 8'hxx, w[8*(k%4) +: 8]);
      end
    end
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if (Overflow !== 1'b0) begin
      fails++;
      $display("FAIL overflow_clear got %b want 0", Overflow);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_collision;
    int n;
    bit to;
    logic [31:0] w;
    rx_q.delete();
    rx_t.delete();
    exp_w = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555, 32'hC011C011};
    for (int i = 0; i < 5; i++) write_word(exp_w[i]);
    n = 0;
    while (TxBusy && n < 400) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (TxBusy !== 1'b0 || Count !== 3'd4) begin
      fails++;
      $display("FAIL collide_setup got Busy=%b Count=%0d want 0 4", TxBusy, Count);
    end
    write_word(exp_w[5]);
    tests++;
    if (Count !== 3'd4 || Full !== 1'b1 || Overflow !== 1'b0 || TxBusy !== 1'b1) begin
      fails++;
      $display("FAIL collide got Count=%0d Full=%b Ovf=%b Busy=%b want 4 1 0 1", Count, Full, Overflow, TxBusy);
    end
    wait_done(2000, to);
    tests++;
    if (to || rx_q.size() !== 24) begin
      fails++;
      $display("FAIL collide_drain got timeout=%b bytes=%0d want 0 24", to, rx_q.size());
    end
    for (int k = 0; k < 24; k++) begin
      w = exp_w[k/4];
      tests++;
      if (k >= rx_q.size() || rx_q[k] !== w[8*(k%4) +: 8]) begin
        fails++;
        $display("FAIL collide_byte%0d got %h want %h", k, (k < rx_q.size()) ? rx_q[k] : 8'hxx, w[8*(k%4) +: 8]);
      end
    end
  endtask

  task automatic test_reset_midframe;
    int act;
    write_word(32'h12340055);
    write_word(32'h87654321);
    repeat (50) @(negedge clk);
    tests++;
    if (TxBusy !== 1'b1 || Tx !== 1'b0 || Count !== 3'd1) begin
      fails++;
      $display("FAIL midframe_setup got Busy=%b Tx=%b Count=%0d want 1 0 1", TxBusy, Tx, Count);
    end
    #2 reset = 1'b1;
    #1;
    tests++;
    if (Tx !== 1'b1 || Count !== 3'd0 || Empty !== 1'b1 || TxBusy !== 1'b0 || Full !== 1'b0) begin
      fails++;
      $display("FAIL midframe_async got Tx=%b Count=%0d Empty=%b Busy=%b Full=%b want 1 0 1 0 0",
               Tx, Count, Empty, TxBusy, Full);
    end
    @(negedge clk);
    reset = 1'b0;
    rx_q.delete();
    rx_t.delete();
    act = 0;
    repeat (100) begin
      @(negedge clk);
      if (Tx !== 1'b1 || TxBusy !== 1'b0 || Count !== 3'd0) act++;
    end
    tests++;
    if (act !== 0 || rx_q.size() !== 0) begin
      fails++;
      $display("FAIL midframe_quiet got %0d active cycles %0d bytes want 0 0", act, rx_q.size());
    end
  endtask

  task automatic test_back_to_back;
    bit to;
    logic [31:0] w;
    rx_q.delete();
    rx_t.delete();
    exp_w = '{32'h000000FF, 32'h80000001};
    write_word(exp_w[0]);
    write_word(exp_w[1]);
    wait_done(1000, to);
    tests++;
    if (to || rx_q.size() !== 8) begin
      fails++;
      $display("FAIL b2b_drain got timeout=%b bytes=%0d want 0 8", to, rx_q.size());
    end
    for (int k = 0; k < 8; k++) begin
      w = exp_w[k/4];
      tests++;
      if (k >= rx_q.size() || rx_q[k] !== w[8*(k%4) +: 8]) begin
        fails++;
        $display("FAIL b2b_byte%0d got %h want %h", k, (k < rx_q.size()) ? rx_q[k] : 8'hxx, w[8*(k%4) +: 8]);
      end
    end
    for (int k = 0; k + 1 < rx_t.size(); k++) begin
      tests++;
      if (rx_t[k+1] - rx_t[k] !== ((k == 3) ? 10 * C + 1 : 10 * C)) begin
        fails++;
        $display("FAIL b2b_gap%0d got %0d want %0d", k, rx_t[k+1] - rx_t[k], (k == 3) ? 10 * C + 1 : 10 * C);
      end
    end
  endtask

  task automatic test_wrap;
    int n;
    bit to;
    logic [31:0] w;
    rx_q.delete();
    rx_t.delete();
    exp_w.delete();
    for (int i = 0; i < 3 * D; i++) exp_w.push_back(32'hA0B0C0D0 ^ (i * 32'h01030507));
    for (int i = 0; i < 3 * D; i++) begin
      n = 0;
      while (Full && n < 400) begin
        @(negedge clk);
        n++;
      end
      tests++;
      if (n >= 400) begin
        fails++;
        $display("FAIL wrap_wait%0d got Full stuck want space", i);
      end
      write_word(exp_w[i]);
    end
    wait_done(3000, to);
    tests++;
    if (to || rx_q.size() !== 12 * D || Overflow !== 1'b0) begin
      fails++;
      $display("FAIL wrap_drain got timeout=%b bytes=%0d Ovf=%b want 0 %0d 0", to, rx_q.size(), Overflow, 12 * D);
    end
    for (int k = 0; k < 12 * D; k++) begin
      w = exp_w[k/4];
      tests++;
      if (k >= rx_q.size() || rx_q[k] !== w[8*(k%4) +: 8]) begin
        fails++;
        $display("FAIL wrap_byte%0d got %h want %h", k, (k < rx_q.size()) ? rx_q[k] : 8'hxx, w[8*(k%4) +: 8]);
      end
    end
    tests++;
    if (stop_err !== 0) begin
      fails++;
      $display("FAIL stop_bits got %0d bad stop bits want 0", stop_err);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_fill();
    test_collision();
    test_reset_midframe();
    test_back_to_back();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
